// File: rtl/vector_collector_pkg.sv
// Shared FP32 constants and collector state encoding.
// Used by vector_collector and fp32_is_special (build option VECTOR_COLLECTOR_NANFLAG_EN).
package vector_collector_pkg;

    localparam int unsigned FP32_W  = 32;
    localparam int unsigned EXP_MSB = 30;
    localparam int unsigned EXP_LSB = 23;

    localparam logic [7:0]        EXP_ONES      = 8'hFF;
    localparam logic [FP32_W-1:0] FP32_POS_ZERO = 32'h0000_0000;

    // Legacy-compatible state encoding
    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

endpackage

// File: rtl/vector_collector_if.sv
// Scalar input stream and packed-vector output stream of the collector.
// master = producer/consumer side, slave = the collector itself.
interface vector_collector_if #(
    parameter int unsigned VLEN = 4
);
    localparam int unsigned CW = $clog2(VLEN + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [32*VLEN-1:0]   out_vector;
    logic [CW-1:0]        out_count;
    logic                 out_err;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_vector, out_count, out_err
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_vector, out_count, out_err
    );

endinterface

// File: rtl/vector_collector_fp32_is_special.sv
// Combinational NaN/Inf detect on one FP32 word (exponent all ones).
module fp32_is_special
    import vector_collector_pkg::*;
(
    input  logic [FP32_W-1:0] word,
    output logic              special
);

    assign special = (word[EXP_MSB:EXP_LSB] == EXP_ONES);

endmodule

// File: rtl/vector_collector.sv
// Packs FP32 scalars into a VLEN-element vector; short vectors are padded with +0.0.
// Build option VECTOR_COLLECTOR_NANFLAG_EN enables the NaN/Inf flag on out_err.
module vector_collector
    import vector_collector_pkg::*;
#(
    parameter int unsigned VLEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    vector_collector_if.slave bus
);

    localparam int unsigned CW = $clog2(VLEN + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(VLEN - 1);

    logic [0:0]              state;
    logic [CW-1:0]           idx;
    logic [FP32_W*VLEN-1:0]  vec;
    logic [CW-1:0]           count;
    logic                    accept;
    logic                    closing;

    assign bus.in_ready   = (state == ST_FILL);
    assign bus.out_valid  = (state == ST_FULL);
    assign bus.out_vector = vec;
    assign bus.out_count  = count;

    assign accept  = bus.in_valid && (state == ST_FILL);
    assign closing = accept && ((idx == LAST_IDX) || bus.in_last);

    // State, element index, packed data and element count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
            idx   <= '0;
            vec   <= '0;
            count <= '0;
        end else if (state == ST_FILL) begin
            if (accept) begin
                for (int unsigned i = 0; i < VLEN; i++) begin
                    if (idx == CW'(i)) begin
                        vec[FP32_W*i +: FP32_W] <= bus.in_data;
                    end
                end
                if (closing) begin
                    state <= ST_FULL;
                    count <= idx + CW'(1);
                    idx   <= '0;
                end else begin
                    idx <= idx + CW'(1);
                end
            end
        end else if (bus.out_ready) begin
            // Clearing on handoff is what makes unwritten slots read +0.0 next time
            state <= ST_FILL;
            for (int unsigned i = 0; i < VLEN; i++) begin
                vec[FP32_W*i +: FP32_W] <= FP32_POS_ZERO;
            end
        end
    end

`ifdef VECTOR_COLLECTOR_NANFLAG_EN
    logic in_special;
    logic err;

    fp32_is_special u_is_special (
        .word    (bus.in_data),
        .special (in_special)
    );

    // Sticky NaN/Inf flag over the vector being collected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept && in_special) begin
            err <= 1'b1;
        end else if ((state == ST_FULL) && bus.out_ready) begin
            err <= 1'b0;
        end
    end

    assign bus.out_err = err;
`else
    assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_vector_collector.sv
// Self-checking bench for vector_collector (VLEN=4) against a queue-based model.
// Honours VECTOR_COLLECTOR_NANFLAG_EN for the out_err expectation.
module tb_vector_collector;

    localparam int unsigned VLEN = 4;
    localparam int unsigned VW   = 32 * VLEN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // Model: elements of the vector being collected, and the pending full vector
    logic [31:0]    m_q[$];
    bit             m_full = 0;
    logic [VW-1:0]  m_vec;
    int             m_cnt;
    bit             m_err;

    always #5 clk = ~clk;

    vector_collector_if #(.VLEN(VLEN)) bus ();

    vector_collector #(.VLEN(VLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] pack_q();
        logic [VW-1:0] v = '0;
        foreach (m_q[k]) v[32*k +: 32] = m_q[k];
        return v;
    endfunction

    function automatic bit any_special();
        bit s = 0;
        foreach (m_q[k]) if (m_q[k][30:23] == 8'hFF) s = 1;
        return s;
    endfunction

    // Called at a falling edge: check outputs, drive inputs, advance model one clock
    task automatic step(input logic v, input logic [31:0] d, input logic l, input logic r);
        check("in_ready", VW'(bus.in_ready), VW'(!m_full));
        check("out_valid", VW'(bus.out_valid), VW'(m_full));
        check("out_vector", bus.out_vector, m_full ? m_vec : pack_q());
        if (m_full) begin
            check("out_count", VW'(bus.out_count), VW'(m_cnt));
            check("out_err", VW'(bus.out_err), VW'(m_err));
        end
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = r;
        if (!m_full) begin
            if (v) begin
                m_q.push_back(d);
                if (m_q.size() == VLEN || l) begin
                    m_full = 1;
                    m_vec  = pack_q();
                    m_cnt  = m_q.size();
`ifdef VECTOR_COLLECTOR_NANFLAG_EN
                    m_err  = any_special();
`else
                    m_err  = 0;
`endif
                    m_q.delete();
                end
            end
        end else if (r) begin
            m_full = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, r);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_vector", bus.out_vector, '0);
        check("rst_out_valid", VW'(bus.out_valid), '0);
        check("rst_in_ready", VW'(bus.in_ready), VW'(1'b1));
        check("rst_count", VW'(bus.out_count), '0);
        check("rst_err", VW'(bus.out_err), '0);
        m_q.delete();
        m_full = 0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        pulse_reset();

        // Back-to-back full vector, out_ready held high
        step(1, 32'h3F800000, 0, 1);
        step(1, 32'h40000000, 0, 1);
        step(1, 32'h40400000, 0, 1);
        step(1, 32'h40800000, 0, 1);
        idle(2, 1);

        // Short vector terminated by in_last, then a 1-element vector
        step(1, 32'h3F800000, 0, 1);
        step(1, 32'h40000000, 1, 1);
        idle(1, 1);
        step(1, 32'h41000000, 1, 1);
        idle(2, 1);

        // Stall in FULL while garbage is offered
        step(1, 32'h11111111, 0, 0);
        step(1, 32'h22222222, 0, 0);
        step(1, 32'h33333333, 0, 0);
        step(1, 32'h44444444, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 32'hDEADBEEF, 0, 0);
        step(0, 32'h0, 0, 1);
        idle(1, 0);

        // Gapped input
        step(1, 32'h3F800000, 0, 0); idle(2, 0);
        step(1, 32'h40000000, 0, 0); idle(2, 0);
        step(1, 32'h40400000, 0, 0); idle(2, 0);
        step(1, 32'h40800000, 0, 0);
        idle(2, 0);
        idle(1, 1);

        // Reset mid-fill discards the partial vector
        step(1, 32'hAAAA0001, 0, 1);
        step(1, 32'hAAAA0002, 0, 1);
        pulse_reset();
        step(1, 32'h00000005, 0, 1);
        step(1, 32'h00000006, 0, 1);
        step(1, 32'h00000007, 0, 1);
        step(1, 32'h00000008, 0, 1);
        idle(1, 1);

        // NaN in element 1, then a clean vector
        step(1, 32'h3F800000, 0, 1);
        step(1, 32'h7FC00000, 0, 1);
        step(1, 32'h40400000, 0, 1);
        step(1, 32'h40800000, 0, 1);
        step(1, 32'h3F800000, 0, 1);
        step(1, 32'h40000000, 1, 1);
        idle(2, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            d = $urandom;
            if ($urandom_range(0, 9) == 0) d[30:23] = 8'hFF;
            step(logic'($urandom_range(0, 9) < 7), d,
                 logic'($urandom_range(0, 9) < 2),
                 logic'($urandom_range(0, 9) < 6));
        end
        idle(3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
